// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit for the multicycle core: owns the PC, issues one fetch
// per instruction over valid/ready, presents {pc, inst} to decode, advances on commit.
module ysyx_24110015_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic        commit_valid,
  input  logic [31:0] pc_next,
  output logic        fetch_fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] to_cnt;
  logic        req_fire, issue_fire, to_hit, pc_aligned;

  assign req_fire   = req_valid && req_ready;
  assign issue_fire = inst_valid && inst_ready;
  assign to_hit     = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign pc_aligned = (pc_next[1:0] == 2'b00);
  assign req_addr   = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // A response wins over the timeout in the last WAIT cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: if (req_fire) state_n = S_WAIT;
      S_WAIT: begin
        if (resp_valid)  state_n = resp_err ? S_FAULT : S_ISSUE;
        else if (to_hit) state_n = S_FAULT;
      end
      S_ISSUE: if (issue_fire) state_n = S_EXEC;
      S_EXEC:  if (commit_valid) state_n = pc_aligned ? S_FETCH : S_FAULT;
      default: state_n = S_FAULT;
    endcase
  end

  // Handshake outputs are flops fed from next-state, so they stay low while
  // rst is held and never see a combinational path from any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid   <= 1'b0;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      req_valid   <= (state_n == S_FETCH);
      inst_valid  <= (state_n == S_ISSUE);
      fetch_fault <= (state_n == S_FAULT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_FETCH: if (req_fire) to_cnt <= '0;
        S_WAIT: begin
          if (resp_valid) begin
            if (!resp_err) inst <= resp_data;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_ISSUE: if (issue_fire) fetch_cnt <= fetch_cnt + 32'd1;
        S_EXEC:  if (commit_valid && pc_aligned) pc <= pc_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Bench for the fetch unit: the bench plays memory and execute, tracking the
// expected PC / count / fault in a small architectural model.
module tb_ysyx_24110015_ifu;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] pc, inst;
  logic        commit_valid;
  logic [31:0] pc_next;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  ysyx_24110015_ifu #(.RESET_PC(RPC), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .inst(inst),
    .commit_valid(commit_valid), .pc_next(pc_next),
    .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  // architectural model
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] mem [logic [31:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_ready = 0; resp_valid = 0; resp_err = 0; resp_data = '0;
    inst_ready = 0; commit_valid = 0; pc_next = '0;
  endtask

  // Holds reset two cycles, releases it and advances to the first FETCH cycle.
  task automatic do_reset();
    rst = 1; idle_inputs();
    for (int i = 0; i < 2; i++) begin
      tick();
      vec++;
      if ({req_valid, inst_valid} !== 2'b00) begin
        miss++; $display("FAIL rst_valids got=%b exp=00", {req_valid, inst_valid});
      end
    end
    rst = 0;
    m_pc = RPC; m_cnt = 0;
    tick();
  endtask

  // One full instruction, starting in a FETCH cycle with req_valid visible.
  task automatic run_instr(input logic [31:0] word, input int req_stall, input int resp_lat,
                           input int issue_stall, input int exec_stall, input logic [31:0] nxt);
    vec++;
    if ({req_valid, req_addr, fetch_fault} !== {1'b1, m_pc, 1'b0}) begin
      miss++; $display("FAIL fetch_req got v=%b a=%h f=%b exp v=1 a=%h f=0", req_valid, req_addr, fetch_fault, m_pc);
    end
    for (int i = 0; i < req_stall; i++) begin
      req_ready = 0; tick();
      vec++;
      if ({req_valid, req_addr} !== {1'b1, m_pc}) begin
        miss++; $display("FAIL req_hold got v=%b a=%h exp v=1 a=%h", req_valid, req_addr, m_pc);
      end
    end
    req_ready = 1; tick(); req_ready = 0;
    vec++;
    if ({req_valid, inst_valid} !== 2'b00) begin
      miss++; $display("FAIL wait_valids got=%b exp=00", {req_valid, inst_valid});
    end
    for (int i = 0; i < resp_lat - 1; i++) tick();
    resp_valid = 1; resp_err = 0; resp_data = word; tick(); resp_valid = 0;
    vec++;
    if ({inst_valid, inst, pc} !== {1'b1, word, m_pc}) begin
      miss++; $display("FAIL issue got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", inst_valid, inst, pc, word, m_pc);
    end
    for (int i = 0; i < issue_stall; i++) begin
      inst_ready = 0;
      resp_valid = 1'($urandom_range(0, 1)); resp_data = $urandom;
      commit_valid = 1'($urandom_range(0, 1)); pc_next = $urandom;
      tick();
      vec++;
      if ({inst_valid, inst, pc, fetch_cnt} !== {1'b1, word, m_pc, m_cnt}) begin
        miss++; $display("FAIL issue_hold got v=%b i=%h pc=%h n=%0d exp v=1 i=%h pc=%h n=%0d",
                         inst_valid, inst, pc, fetch_cnt, word, m_pc, m_cnt);
      end
    end
    resp_valid = 0; commit_valid = 0; inst_ready = 1; tick(); inst_ready = 0;
    m_cnt++;
    vec++;
    if ({inst_valid, fetch_cnt, inst} !== {1'b0, m_cnt, word}) begin
      miss++; $display("FAIL handoff got v=%b n=%0d i=%h exp v=0 n=%0d i=%h", inst_valid, fetch_cnt, inst, m_cnt, word);
    end
    for (int i = 0; i < exec_stall; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      resp_valid = 1'($urandom_range(0, 1)); resp_data = $urandom;
      tick();
      vec++;
      if ({inst, pc, fetch_cnt, req_valid, inst_valid} !== {word, m_pc, m_cnt, 2'b00}) begin
        miss++; $display("FAIL exec_hold got i=%h pc=%h n=%0d rv=%b iv=%b exp i=%h pc=%h n=%0d rv=0 iv=0",
                         inst, pc, fetch_cnt, req_valid, inst_valid, word, m_pc, m_cnt);
      end
    end
    inst_ready = 0; resp_valid = 0;
    commit_valid = 1; pc_next = nxt; tick(); commit_valid = 0;
    vec++;
    if (nxt[1:0] == 2'b00) begin
      m_pc = nxt;
      if ({req_valid, req_addr, fetch_fault} !== {1'b1, nxt, 1'b0}) begin
        miss++; $display("FAIL commit got v=%b a=%h f=%b exp v=1 a=%h f=0", req_valid, req_addr, fetch_fault, nxt);
      end
    end else begin
      if ({fetch_fault, req_valid, inst_valid, pc} !== {3'b100, m_pc}) begin
        miss++; $display("FAIL misalign got f=%b rv=%b iv=%b pc=%h exp f=1 rv=0 iv=0 pc=%h",
                         fetch_fault, req_valid, inst_valid, pc, m_pc);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({req_valid, req_addr, pc, fetch_cnt, fetch_fault, inst_valid, inst} !==
        {1'b1, RPC, RPC, 32'd0, 2'b00, 32'd0}) begin
      miss++; $display("FAIL reset_state got v=%b a=%h pc=%h n=%0d f=%b iv=%b i=%h",
                       req_valid, req_addr, pc, fetch_cnt, fetch_fault, inst_valid, inst);
    end
  endtask

  task automatic test_straight_line();
    run_instr(32'h0010_0093, 0, 1, 0, 0, RPC + 32'd4);
    vec++;
    if (fetch_cnt !== 32'd1) begin
      miss++; $display("FAIL straight_cnt got=%0d exp=1", fetch_cnt);
    end
  endtask

  task automatic test_backpressure();
    run_instr(32'h0020_8113, 3, 1, 4, 0, m_pc + 32'd4);
    vec++;
    if (fetch_cnt !== 32'd2) begin
      miss++; $display("FAIL bp_cnt got=%0d exp=2", fetch_cnt);
    end
  endtask

  task automatic test_jump_misalign();
    run_instr(32'h0fc0_006f, 0, 2, 0, 2, 32'h8000_0100);
    run_instr(32'h0000_0067, 1, 1, 1, 1, 32'h8000_0102);
    for (int i = 0; i < 3; i++) begin
      req_ready = 1; resp_valid = 1; inst_ready = 1; commit_valid = 1; pc_next = 32'h8000_0200;
      tick();
      vec++;
      if ({fetch_fault, req_valid, inst_valid, pc} !== {3'b100, 32'h8000_0100}) begin
        miss++; $display("FAIL fault_sticky got f=%b rv=%b iv=%b pc=%h exp f=1 rv=0 iv=0 pc=80000100",
                         fetch_fault, req_valid, inst_valid, pc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_resp_err();
    do_reset();
    req_ready = 1; tick(); req_ready = 0;
    resp_valid = 1; resp_err = 1; resp_data = 32'h1234_5678; tick();
    resp_valid = 0; resp_err = 0;
    vec++;
    if ({fetch_fault, req_valid, inst_valid, inst} !== {3'b100, 32'd0}) begin
      miss++; $display("FAIL resp_err got f=%b rv=%b iv=%b i=%h exp f=1 rv=0 iv=0 i=0",
                       fetch_fault, req_valid, inst_valid, inst);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_ready = 1; tick(); req_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      vec++;
      if (fetch_fault !== (i == 4)) begin
        miss++; $display("FAIL timeout cyc=%0d got=%b exp=%b", i, fetch_fault, (i == 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vec++;
    if (fetch_fault !== 1'b0) begin
      miss++; $display("FAIL fault_clear got=%b exp=0", fetch_fault);
    end
    run_instr(32'h0040_0213, 0, 1, 0, 0, RPC + 32'h40);
    req_ready = 1; tick(); req_ready = 0;
    rst = 1; resp_valid = 1; resp_data = 32'hdead_beef; tick();
    vec++;
    if ({pc, fetch_fault, fetch_cnt, inst, req_valid, inst_valid} !== {RPC, 1'b0, 32'd0, 32'd0, 2'b00}) begin
      miss++; $display("FAIL rst_mid got pc=%h f=%b n=%0d i=%h rv=%b iv=%b",
                       pc, fetch_fault, fetch_cnt, inst, req_valid, inst_valid);
    end
    tick();
    rst = 0; resp_valid = 0; m_pc = RPC; m_cnt = 0;
    tick();
    vec++;
    if ({req_valid, req_addr, inst} !== {1'b1, RPC, 32'd0}) begin
      miss++; $display("FAIL rst_mid_refetch got v=%b a=%h i=%h exp v=1 a=%h i=0", req_valid, req_addr, inst, RPC);
    end
    run_instr(32'h0050_0293, 0, 3, 1, 0, RPC + 32'd4);
  endtask

  task automatic test_random();
    logic [31:0] w, j, nxt;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      if (!mem.exists(m_pc)) mem[m_pc] = $urandom;
      w = mem[m_pc];
      j = $urandom;
      nxt = ($urandom_range(0, 3) != 0) ? m_pc + 32'd4 : {j[31:2], 2'b00};
      run_instr(w, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), nxt);
    end
    vec++;
    if (fetch_cnt !== 32'd150) begin
      miss++; $display("FAIL random_cnt got=%0d exp=150", fetch_cnt);
    end
  endtask

  initial begin
    rst = 1; idle_inputs();
    test_reset();
    test_straight_line();
    test_backpressure();
    test_jump_misalign();
    test_resp_err();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
